// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: funct codes and FSM states.
package muldiv_unit_pkg;

  // R-type funct codes handled beside the ALU
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_MUL,
    MD_DIV,
    MD_FIX
  } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
// Multiply: {hi,lo} holds {partial product, remaining multiplier}; add-then-shift-right.
// Divide:   {hi,lo} holds {partial remainder, dividend/quotient}; shift-left-then-subtract.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Single shift-add or restoring shift-subtract step
  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    shifted = {hi_i, lo_i[WIDTH-1]};
    ge      = (shifted >= {1'b0, opnd_i});
    // When ge holds the true difference is below the divisor, so WIDTH bits suffice.
    diff    = shifted[WIDTH-1:0] - opnd_i;
    if (div_mode_i) begin
      hi_o = ge ? diff : shifted[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], ge};
    end else begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO pair.
// Operates on magnitudes and fixes signs in a final FIX cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, illegal_q, illegal_d;

  // Working datapath registers (no reset; only meaningful while busy)
  logic [WIDTH-1:0] wh_q, wh_d, wl_q, wl_d, opnd_q, opnd_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d, mul_q, mul_d;

  logic [WIDTH-1:0]   step_hi, step_lo;
  logic               sgn;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic signed_op);
    return (signed_op && v[WIDTH-1]) ? -v : v;
  endfunction

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode_i (state_q == MD_DIV),
    .hi_i       (wh_q),
    .lo_i       (wl_q),
    .opnd_i     (opnd_q),
    .hi_o       (step_hi),
    .lo_o       (step_lo)
  );

  // Next-state: request decode, iteration, and sign fix-up
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    wh_d      = wh_q;
    wl_d      = wl_q;
    opnd_d    = opnd_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    mul_d     = mul_q;
    sgn       = 1'b0;
    prod      = '0;
    quo       = '0;
    rem       = '0;
    if (flush) begin
      // Squash wins over accept and over a pending HI/LO write
      state_d = MD_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (in_valid) begin
            case (funct)
              FUNCT_MULT, FUNCT_MULTU: begin
                sgn     = (funct == FUNCT_MULT);
                state_d = MD_MUL;
                cnt_d   = '0;
                mul_d   = 1'b1;
                wh_d    = '0;
                wl_d    = mag(op_b, sgn);
                opnd_d  = mag(op_a, sgn);
                qneg_d  = sgn && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                rneg_d  = 1'b0;
                dz_d    = 1'b0;
              end
              FUNCT_DIV, FUNCT_DIVU: begin
                sgn     = (funct == FUNCT_DIV);
                state_d = MD_DIV;
                cnt_d   = '0;
                mul_d   = 1'b0;
                wh_d    = '0;
                wl_d    = mag(op_a, sgn);
                opnd_d  = mag(op_b, sgn);
                qneg_d  = sgn && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                rneg_d  = sgn && op_a[WIDTH-1];
                dz_d    = (op_b == '0);
              end
              FUNCT_MTHI: hi_d = op_a;
              FUNCT_MTLO: lo_d = op_a;
              FUNCT_MFHI, FUNCT_MFLO: ;
              default: illegal_d = 1'b1;
            endcase
          end
        end
        MD_MUL, MD_DIV: begin
          wh_d  = step_hi;
          wl_d  = step_lo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = MD_FIX;
        end
        MD_FIX: begin
          if (mul_q) begin
            prod = {wh_q, wl_q};
            if (qneg_q) prod = -prod;
            {hi_d, lo_d} = prod;
          end else begin
            quo = qneg_q ? -wl_q : wl_q;
            rem = rneg_q ? -wh_q : wh_q;
            // Divide by zero: remainder already equals the dividend, quotient forced to all ones
            if (dz_q) quo = '1;
            hi_d = rem;
            lo_d = quo;
          end
          done_d  = 1'b1;
          state_d = MD_IDLE;
        end
        default: state_d = MD_IDLE;
      endcase
    end
  end

  // Control and architectural state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  // Working datapath registers
  always_ff @(posedge clk) begin
    wh_q   <= wh_d;
    wl_q   <= wl_d;
    opnd_q <= opnd_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
    dz_q   <= dz_d;
    mul_q  <= mul_d;
  end

  assign busy    = (state_q != MD_IDLE);
  assign done    = done_q;
  assign illegal = illegal_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule
